// File: rtl/sfifoarb_pkg.sv
// Shared state encoding and sizing helpers for the FIFO drain arbiter.
package sfifoarb_pkg;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int maxburst(input int lgburst);
        return 1 << lgburst;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after a start pointer, wrapping.
module rr_pick
    import sfifoarb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int SW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [SW-1:0]   i_ptr,
    output logic            o_valid,
    output logic [SW-1:0]   o_idx
);

    logic [SW-1:0] k;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        k       = '0;
        // Scan from the farthest offset down so the nearest hit overwrites the rest.
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = SW'((int'(i_ptr) + i) % NREQ);
            if (i_req[k]) begin
                o_valid = 1'b1;
                o_idx   = k;
            end
        end
    end

endmodule

// File: rtl/sfifo_drain_arb.sv
// Round-robin burst drain scheduler for a bank of threshold-flagged FIFOs.
// Optional starvation flush of sub-threshold tails: define SFIFOARB_FLUSH_EN.
module sfifo_drain_arb
    import sfifoarb_pkg::*;
#(
    parameter  int NREQ         = 4,
    parameter  int BW           = 8,
    parameter  int LGFLEN       = 4,
    parameter  int LGBURST      = 3,
    parameter  int FLUSH_CYCLES = 64,
    localparam int SW           = clog2(NREQ),
    localparam int FW           = LGFLEN + 1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [NREQ-1:0]  i_int,
    input  logic [NREQ-1:0]  i_empty,
    input  logic [NREQ*FW-1:0] i_fill,
    input  logic [NREQ*BW-1:0] i_data,
    output logic [NREQ-1:0]  o_rd,
    output logic             o_valid,
    output logic [BW-1:0]    o_data,
    output logic [SW-1:0]    o_src,
    output logic             o_last,
    input  logic             i_ready,
    output logic             o_busy
);

    localparam int RW       = LGBURST + 1;
    localparam int MAXBURST = maxburst(LGBURST);

    if (NREQ < 2 || NREQ > 16 || FLUSH_CYCLES < 1) begin : g_bad_cfg
        $error("sfifo_drain_arb: unsupported parameter set");
    end

    logic [0:0]      state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d, rr_ptr_q, rr_ptr_d;
    logic [RW-1:0]   rem_q, rem_d, grant_len;
    logic [NREQ-1:0] eligible;
    logic            pick_valid;
    logic [SW-1:0]   pick_idx;
    logic            busy, beat;
    logic [FW-1:0]   fill_arr [NREQ];
    logic [BW-1:0]   data_arr [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign fill_arr[k] = i_fill[k*FW +: FW];
        assign data_arr[k] = i_data[k*BW +: BW];
    end

    assign busy = (state_q == BURST);
    assign beat = busy && i_ready;

`ifdef SFIFOARB_FLUSH_EN
    localparam int CW = clog2(FLUSH_CYCLES + 1);
    logic [NREQ-1:0] flushed;

    for (genvar k = 0; k < NREQ; k++) begin : g_flush
        logic [CW-1:0] cnt_q;
        logic          granted;

        assign granted    = busy ? (sel_q == SW'(k)) : (pick_valid && pick_idx == SW'(k));
        assign flushed[k] = (cnt_q >= CW'(FLUSH_CYCLES));

        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                cnt_q <= '0;
            end else if (granted || i_empty[k] || i_int[k]) begin
                cnt_q <= '0;
            end else if (!flushed[k]) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign eligible = (i_int | flushed) & ~i_empty;
`else
    assign eligible = i_int & ~i_empty;
`endif

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .i_req   (eligible),
        .i_ptr   (rr_ptr_q),
        .o_valid (pick_valid),
        .o_idx   (pick_idx)
    );

    // Full-width fill compare so deep FIFOs never alias onto a short burst.
    always_comb begin
        if (32'(fill_arr[pick_idx]) >= MAXBURST) grant_len = RW'(MAXBURST);
        else                                     grant_len = RW'(fill_arr[pick_idx]);
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rem_d    = rem_q;
        rr_ptr_d = rr_ptr_q;
        if (!busy) begin
            if (pick_valid) begin
                state_d = BURST;
                sel_d   = pick_idx;
                rem_d   = grant_len;
            end
        end else if (beat) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == RW'(1)) begin
                state_d  = IDLE;
                rr_ptr_d = (sel_q == SW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rem_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rem_q    <= rem_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign o_busy  = busy;
    assign o_valid = busy;
    assign o_src   = sel_q;
    assign o_data  = data_arr[sel_q];
    assign o_last  = busy && (rem_q == RW'(1));

    always_comb begin
        o_rd = '0;
        if (beat) o_rd[sel_q] = 1'b1;
    end

endmodule
